// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings, winner codes and UART command bytes for the Pong controller
package pong_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4,
    ST_PAUSE     = 3'd5
  } state_t;
  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_RESET = 8'h52;
endpackage

// File: rtl/pong_serve_timer.sv
// pong_serve_timer: counts frame ticks during a serve and pulses o_Done on the last one
//   i_Clk, i_Rst (sync, active-high), i_Clear (restart count), i_Tick (frame pulse),
//   i_Hold (freeze count), o_Done (combinational pulse on the tick that ends the serve)
module pong_serve_timer #(
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Tick,
  input  logic i_Hold,
  output logic o_Done
);
  localparam int CW = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SERVE_DELAY_FRAMES - 1);
  logic [CW-1:0] cnt;
  logic          adv;
  assign adv    = i_Tick && !i_Hold;
  assign o_Done = adv && (cnt == LAST);
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) cnt <= '0;
    else if (adv) cnt <= o_Done ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match flow controller (idle/serve/play/point/game-over) with score keeping
//   i_Clk, i_Rst (sync, active-high); i_Frame_Tick, i_Start, i_P1_Miss, i_P2_Miss pulses;
//   i_RX_DV/i_RX_Byte UART commands ('S' start, 'P' pause toggle, 'R' reset) when
//   PONG_UART_CMD_EN is defined, ignored otherwise.
//   o_Ball_En, o_Ball_Reset, o_Serve_Dir, o_P1_Score, o_P2_Score, o_Winner, o_State.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_LIMIT        = 9,
  parameter int SCORE_WIDTH        = 4,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Frame_Tick,
  input  logic                   i_Start,
  input  logic                   i_P1_Miss,
  input  logic                   i_P2_Miss,
  input  logic                   i_RX_DV,
  input  logic [7:0]             i_RX_Byte,
  output logic                   o_Ball_En,
  output logic                   o_Ball_Reset,
  output logic                   o_Serve_Dir,
  output logic [SCORE_WIDTH-1:0] o_P1_Score,
  output logic [SCORE_WIDTH-1:0] o_P2_Score,
  output logic [1:0]             o_Winner,
  output logic [2:0]             o_State
);
  localparam logic [SCORE_WIDTH-1:0] LIM = SCORE_WIDTH'(SCORE_LIMIT);
  state_t  state, state_nxt;
  winner_t winner;
  logic    start, pause_cmd, reset_cmd, serve_done, enter_serve, miss;
`ifdef PONG_UART_CMD_EN
  // A UART command outranks a same-cycle switch pulse: 'R' overrides everything below it.
  assign start     = (i_RX_DV && i_RX_Byte == CMD_START) || i_Start;
  assign pause_cmd = i_RX_DV && i_RX_Byte == CMD_PAUSE;
  assign reset_cmd = i_RX_DV && i_RX_Byte == CMD_RESET;
`else
  logic unused_rx;
  assign unused_rx = ^{i_RX_DV, i_RX_Byte};
  assign start     = i_Start;
  assign pause_cmd = 1'b0;
  assign reset_cmd = 1'b0;
`endif
  assign miss        = i_P1_Miss || i_P2_Miss;
  assign enter_serve = (state_nxt == ST_SERVE) && (state != ST_SERVE);
  pong_serve_timer #(.SERVE_DELAY_FRAMES(SERVE_DELAY_FRAMES)) u_timer (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Clear(enter_serve),
    .i_Tick (i_Frame_Tick && state == ST_SERVE),
    .i_Hold (state == ST_PAUSE),
    .o_Done (serve_done)
  );
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      state_nxt = start ? ST_SERVE : ST_IDLE;
      ST_SERVE:     state_nxt = serve_done ? ST_PLAY : ST_SERVE;
      ST_PLAY:      state_nxt = pause_cmd ? ST_PAUSE : miss ? ST_POINT : ST_PLAY;
      ST_POINT:     state_nxt = (o_P1_Score == LIM || o_P2_Score == LIM) ? ST_GAME_OVER : ST_SERVE;
      ST_GAME_OVER: state_nxt = start ? ST_SERVE : ST_GAME_OVER;
      ST_PAUSE:     state_nxt = pause_cmd ? ST_PLAY : ST_PAUSE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (reset_cmd) state_nxt = ST_IDLE;
  end
  always_comb begin
    o_Ball_En = state == ST_PLAY;
    o_State   = state;
    o_Winner  = winner;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Ball_Reset <= 1'b0;
      o_Serve_Dir  <= 1'b0;
      o_P1_Score   <= '0;
      o_P2_Score   <= '0;
      winner       <= WIN_NONE;
    end else begin
      o_Ball_Reset <= enter_serve;
      if (reset_cmd || (state == ST_GAME_OVER && enter_serve)) begin
        o_P1_Score <= '0;
        o_P2_Score <= '0;
        winner     <= WIN_NONE;
      end else if (state == ST_PLAY && state_nxt == ST_POINT) begin
        // P1's miss wins a tie; the P2 miss in the same cycle is dropped.
        if (i_P1_Miss) begin
          o_P2_Score  <= o_P2_Score + 1'b1;
          o_Serve_Dir <= 1'b0;
        end else begin
          o_P1_Score  <= o_P1_Score + 1'b1;
          o_Serve_Dir <= 1'b1;
        end
      end else if (state == ST_POINT && state_nxt == ST_GAME_OVER) begin
        winner <= (o_P1_Score == LIM) ? WIN_P1 : WIN_P2;
      end
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed vector bench for pong_game_ctrl with SCORE_LIMIT=2, SERVE_DELAY_FRAMES=3
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, start = 1'b0, m1 = 1'b0, m2 = 1'b0, dv = 1'b0;
  logic [7:0] rx = 8'h00;
  logic       ball_en, ball_reset, serve_dir;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state;
  int         n_cmp = 0;
  int         n_fail = 0;
  typedef struct packed {
    logic        r, st, a, b, tk;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];
  pong_game_ctrl #(.SCORE_LIMIT(2), .SCORE_WIDTH(4), .SERVE_DELAY_FRAMES(3)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Frame_Tick(tick),
    .i_Start     (start),
    .i_P1_Miss   (m1),
    .i_P2_Miss   (m2),
    .i_RX_DV     (dv),
    .i_RX_Byte   (rx),
    .o_Ball_En   (ball_en),
    .o_Ball_Reset(ball_reset),
    .o_Serve_Dir (serve_dir),
    .o_P1_Score  (p1_score),
    .o_P2_Score  (p2_score),
    .o_Winner    (winner),
    .o_State     (state)
  );
  always #20 clk = ~clk;
  function automatic logic [15:0] ex(int s, int en, int br, int a, int b, int w, int d);
    return {3'(s), 1'(en), 1'(br), 4'(a), 4'(b), 2'(w), 1'(d)};
  endfunction
  function automatic vec_t mk(int r, int st, int a, int b, int tk, logic [15:0] e);
    vec_t v;
    v.r = 1'(r); v.st = 1'(st); v.a = 1'(a); v.b = 1'(b); v.tk = 1'(tk); v.exp = e;
    return v;
  endfunction
  task automatic drive(input logic r, st, a, b, tk, d, input logic [7:0] by);
    @(negedge clk);
    rst = r; start = st; m1 = a; m2 = b; tick = tk; dv = d; rx = by;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [15:0] e);
    logic [15:0] got;
    got = {state, ball_en, ball_reset, p1_score, p2_score, winner, serve_dir};
    n_cmp++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s got st=%0d en=%0d br=%0d p1=%0d p2=%0d w=%b dir=%0d required st=%0d en=%0d br=%0d p1=%0d p2=%0d w=%b dir=%0d",
               name, got[15:13], got[12], got[11], got[10:7], got[6:3], got[2:1], got[0],
               e[15:13], e[12], e[11], e[10:7], e[6:3], e[2:1], e[0]);
    end
  endtask
  initial begin
    int  ticks;
    bit  ok;
    tbl.push_back(mk(1,0,0,0,0, ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0, ex(1,0,1,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,0, ex(1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,1, ex(1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,1,0, ex(1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(2,1,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0, ex(2,1,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(3,0,0,1,0,0,1)));
    tbl.push_back(mk(0,0,0,0,0, ex(1,0,1,1,0,0,1)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,1,0,0,1)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,1,0,0,1)));
    tbl.push_back(mk(0,0,0,0,1, ex(2,1,0,1,0,0,1)));
    tbl.push_back(mk(0,0,1,1,0, ex(3,0,0,1,1,0,0)));
    tbl.push_back(mk(0,0,0,0,0, ex(1,0,1,1,1,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,1,1,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,1,1,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(2,1,0,1,1,0,0)));
    tbl.push_back(mk(0,0,1,0,1, ex(3,0,0,1,2,0,0)));
    tbl.push_back(mk(0,0,0,0,0, ex(4,0,0,1,2,2,0)));
    tbl.push_back(mk(0,0,1,0,0, ex(4,0,0,1,2,2,0)));
    tbl.push_back(mk(0,1,0,0,0, ex(1,0,1,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,1, ex(1,0,0,0,0,0,0)));
    tbl.push_back(mk(1,0,0,0,1, ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,0, ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0, ex(1,0,1,0,0,0,0)));
    tbl.push_back(mk(0,0,0,0,0, ex(1,0,0,0,0,0,0)));
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].tk, 1'b0, 8'h00);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    ticks = 0;
    ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      drive(0, 0, 0, 0, (i % 2) == 0, 0, 8'h00);
      if ((i % 2) == 0) ticks++;
      if (state == 3'd2) ok = 1;
    end
    n_cmp++;
    if (!ok || ticks != 3 || ball_en !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_wait got ok=%0d ticks=%0d en=%b required ok=1 ticks=3 en=1", ok, ticks, ball_en);
    end
`ifdef PONG_UART_CMD_EN
    drive(0, 0, 0, 0, 0, 1, 8'h50);
    check("uart_pause", ex(5,0,0,0,0,0,0));
    drive(0, 0, 1, 0, 0, 0, 8'h00);
    check("pause_miss", ex(5,0,0,0,0,0,0));
    drive(0, 0, 0, 0, 1, 0, 8'h00);
    check("pause_tick", ex(5,0,0,0,0,0,0));
    drive(0, 0, 0, 0, 0, 1, 8'h50);
    check("uart_resume", ex(2,1,0,0,0,0,0));
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    check("uart_point", ex(3,0,0,1,0,0,1));
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    check("uart_serve", ex(1,0,1,1,0,0,1));
    drive(0, 0, 0, 0, 0, 1, 8'h50);
    check("pause_in_serve", ex(1,0,0,1,0,0,1));
    drive(0, 0, 0, 0, 0, 1, 8'h52);
    check("uart_reset", ex(0,0,0,0,0,0,1));
    drive(0, 1, 0, 0, 0, 1, 8'h52);
    check("uart_priority", ex(0,0,0,0,0,0,1));
    drive(0, 0, 0, 0, 0, 1, 8'h53);
    check("uart_start", ex(1,0,1,0,0,0,1));
    drive(0, 0, 0, 0, 0, 1, 8'h41);
    check("uart_other", ex(1,0,0,0,0,0,1));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
